// File: rtl/stage_ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit:
// aluop encodings and the control FSM state type.
package stage_ex_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_e;

  function automatic logic is_div_op(
    input logic [2:0] op
  );
    return op[2];
  endfunction

  function automatic logic is_rem_op(
    input logic [2:0] op
  );
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/stage_ex_muldiv_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// quot_o/rem_o carry the values produced by the current step.
module muldiv_divider
  import stage_ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            abort_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;

  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] quot_step;
  logic [XLEN-1:0] rem_step;

  always_comb begin
    shifted   = {rem_q, quot_q[XLEN-1]};
    fits      = shifted >= {1'b0, dvsr_q};
    rem_step  = fits ? XLEN'(shifted - {1'b0, dvsr_q})
                     : shifted[XLEN-1:0];
    quot_step = {quot_q[XLEN-2:0], fits};

    busy_d = busy_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dvsr_d = dvsr_q;

    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quot_d = dividend_i;
      rem_d  = '0;
      dvsr_d = divisor_i;
    end else if (busy_q) begin
      quot_d = quot_step;
      rem_d  = rem_step;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end

    if (abort_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvsr_q <= dvsr_d;
    end
  end

  assign done_o = busy_q && (cnt_q == LAST);
  assign quot_o = quot_step;
  assign rem_o  = rem_step;

endmodule

// File: rtl/stage_ex_muldiv.sv
// EX-stage RV32M multiply/divide unit. MULDIV_FAST_MUL_EN selects a
// single-cycle multiplier instead of the iterative shift-add one.
module stage_ex_muldiv
  import stage_ex_muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            aluop,
  input  logic [XLEN-1:0]       op1,
  input  logic [XLEN-1:0]       op2,
  input  logic                  write_i,
  input  logic [REG_ADDR_W-1:0] regw_addr_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  write_o,
  output logic [REG_ADDR_W-1:0] regw_addr_o,
  output logic [XLEN-1:0]       regw_data,
  output logic                  stall_ex
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            op_q, op_d;
  logic                  wr_q, wr_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic                  neg_q, neg_d;
  logic [XLEN-1:0]       mcand_q, mcand_d;
  logic [2*XLEN-1:0]     prod_q, prod_d;
  logic [XLEN-1:0]       res_q, res_d;

  logic                  accept;
  logic                  a_sgn, b_sgn;
  logic                  a_neg, b_neg;
  logic [XLEN-1:0]       abs_a, abs_b;
  logic [XLEN:0]         mul_sum;
  logic [2*XLEN-1:0]     mul_next;
  logic                  div_start, div_done;
  logic [XLEN-1:0]       div_quot, div_rem;

  function automatic logic [XLEN-1:0] mul_sel(
    input logic [2:0]        op,
    input logic              neg,
    input logic [2*XLEN-1:0] p
  );
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    if (op == OP_MUL) return s[XLEN-1:0];
    return s[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] div_sel(
    input logic [2:0]      op,
    input logic            neg,
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r
  );
    logic [XLEN-1:0] x;
    x = is_rem_op(op) ? r : q;
    return neg ? -x : x;
  endfunction

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (aluop)
      OP_MULH, OP_DIV, OP_REM: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      OP_MULHSU: a_sgn = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = a_sgn & op1[XLEN-1];
  assign b_neg = b_sgn & op2[XLEN-1];
  assign abs_a = a_neg ? -op1 : op1;
  assign abs_b = b_neg ? -op2 : op2;

  assign accept = valid_i && (state_q == IDLE) && !flush;

  // Right-shifting accumulator: high half sums, low half holds multiplier.
  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]}
                  + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, prod_q[XLEN-1:1]};

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, abs_a}
                   * {{XLEN{1'b0}}, abs_b};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    neg_d     = neg_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    res_d     = res_q;
    div_start = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = aluop;
          wr_d   = write_i;
          addr_d = regw_addr_i;
          cnt_d  = '0;
          if (is_div_op(aluop)) begin
            neg_d = is_rem_op(aluop) ? a_neg
                                     : a_neg ^ b_neg;
            if (op2 == '0) begin
              state_d = DONE;
              res_d   = is_rem_op(aluop) ? op1 : '1;
            end else if (a_sgn && op1 == MIN_NEG
                         && op2 == '1) begin
              state_d = DONE;
              res_d   = is_rem_op(aluop) ? '0 : op1;
            end else begin
              state_d   = DIV;
              div_start = 1'b1;
            end
          end else begin
            neg_d = a_neg ^ b_neg;
`ifdef MULDIV_FAST_MUL_EN
            state_d = DONE;
            res_d   = mul_sel(aluop, a_neg ^ b_neg,
                              fast_prod);
`else
            state_d = MUL;
            mcand_d = abs_a;
            prod_d  = {{XLEN{1'b0}}, abs_b};
`endif
          end
        end
      end
      MUL: begin
        prod_d = mul_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          res_d   = mul_sel(op_q, neg_q, mul_next);
        end
      end
      DIV: begin
        if (div_done) begin
          state_d = DONE;
          res_d   = div_sel(op_q, neg_q,
                            div_quot, div_rem);
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      prod_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      neg_q   <= neg_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
    end
  end

  muldiv_divider #(
    .XLEN(XLEN)
  ) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .abort_i   (flush),
    .start_i   (div_start),
    .dividend_i(abs_a),
    .divisor_i (abs_b),
    .done_o    (div_done),
    .quot_o    (div_quot),
    .rem_o     (div_rem)
  );

  assign ready_o     = (state_q == IDLE);
  assign stall_ex    = (state_q != IDLE);
  assign valid_o     = (state_q == DONE);
  assign write_o     = valid_o & wr_q;
  assign regw_addr_o = valid_o ? addr_q : '0;
  assign regw_data   = valid_o ? res_q : '0;

endmodule

// File: tb/tb_stage_ex_muldiv.sv
// Directed bench for stage_ex_muldiv with an arithmetic reference model.
// Build with MULDIV_FAST_MUL_EN to check the single-cycle multiplier.
module tb_stage_ex_muldiv;
  import stage_ex_muldiv_pkg::*;

  localparam int XLEN = 32;
  localparam int AW   = 5;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            flush;
  logic            valid_i;
  logic            ready_o;
  logic [2:0]      aluop;
  logic [XLEN-1:0] op1, op2;
  logic            write_i;
  logic [AW-1:0]   regw_addr_i;
  logic            valid_o;
  logic            ready_i;
  logic            write_o;
  logic [AW-1:0]   regw_addr_o;
  logic [XLEN-1:0] regw_data;
  logic            stall_ex;

  stage_ex_muldiv #(
    .XLEN(XLEN),
    .REG_ADDR_W(AW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .aluop      (aluop),
    .op1        (op1),
    .op2        (op2),
    .write_i    (write_i),
    .regw_addr_i(regw_addr_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .write_o    (write_o),
    .regw_addr_o(regw_addr_o),
    .regw_data  (regw_data),
    .stall_ex   (stall_ex)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int passed = 0;

  logic        pending = 1'b0;
  logic        seen = 1'b0;
  logic [31:0] exp_data = '0;
  logic        exp_wr = 1'b0;
  logic [4:0]  exp_addr = '0;
  int          exp_lat = 0;
  int          acc_cyc = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  name, act, exp);
  endtask

  function automatic logic [31:0] model_res(
    input logic [2:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic [31:0]     r;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    r   = '0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF
              : ovf ? a : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: r = (b == 0) ? a : 32'(ua % ub);
    endcase
    return r;
  endfunction

  function automatic int model_lat(
    input logic [2:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    if (op < 4) return MUL_LAT;
    if (b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000
        && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Compare process: outputs against the model on every cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      check("stall_vs_ready", stall_ex, !ready_o);
      if (valid_o) begin
        if (!pending) begin
          check("unexpected_valid", valid_o, 0);
        end else begin
          if (!seen) begin
            check("model_latency", cyc - acc_cyc + 1, exp_lat);
            seen = 1'b1;
          end
          check("model_result", regw_data, exp_data);
          check("wb_fields", {write_o, regw_addr_o},
                {exp_wr, exp_addr});
        end
      end else begin
        check("idle_outputs",
              {write_o, regw_addr_o, regw_data}, '0);
      end
    end
  end

  task automatic start_req(input logic [2:0] op,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input logic [4:0] rd);
    @(posedge clk); #1;
    valid_i = 1'b1;
    aluop = op;
    op1 = a;
    op2 = b;
    regw_addr_i = rd;
    write_i = (rd != 0);
    check("ready_before_accept", ready_o, 1);
    @(posedge clk); #1;
    valid_i  = 1'b0;
    exp_data = model_res(op, a, b);
    exp_lat  = model_lat(op, a, b);
    exp_wr   = (rd != 0);
    exp_addr = rd;
    acc_cyc  = cyc;
    seen     = 1'b0;
    pending  = 1'b1;
  endtask

  task automatic run_op(input string name,
                        input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] rd,
                        input logic [31:0] lit,
                        input int lit_lat,
                        input int hold);
    int n;
    start_req(op, a, b, rd);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid_o && n < 100);
    if (!valid_o) begin
      check({name, "_timeout"}, valid_o, 1);
      @(posedge clk); #1;
      flush = 1'b1;
      pending = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      return;
    end
    check({name, "_latency"}, n, lit_lat);
    check({name, "_data"}, regw_data, lit);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, valid_o, 1);
      check({name, "_hold_data"}, regw_data, lit);
    end
    ready_i = 1'b1;
    check({name, "_ready_in_done"}, ready_o, 0);
    @(posedge clk); #1;
    ready_i = 1'b0;
    pending = 1'b0;
    check({name, "_ready_after"}, ready_o, 1);
    check({name, "_valid_after"}, valid_o, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    flush = 1'b0;
    valid_i = 1'b0;
    aluop = '0;
    op1 = '0;
    op2 = '0;
    write_i = 1'b0;
    regw_addr_i = '0;
    ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready_o, 1);
    check("rst_stall", stall_ex, 0);
    check("rst_valid", valid_o, 0);
    check("rst_data", regw_data, 0);
    reset_n = 1'b1;

    run_op("mul_7xm3", OP_MUL, 32'd7, 32'hFFFF_FFFD,
           5'd3, 32'hFFFF_FFEB, MUL_LAT, 0);
    run_op("mulhu_max", OP_MULHU, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, MUL_LAT, 0);
    run_op("mulh_m1", OP_MULH, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 5'd5, 32'h0, MUL_LAT, 0);
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFE, 32'd3,
           5'd6, 32'hFFFF_FFFF, MUL_LAT, 0);
    run_op("mulh_min", OP_MULH, 32'h8000_0000,
           32'h8000_0000, 5'd7, 32'h4000_0000, MUL_LAT, 0);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
           5'd8, 32'hFFFF_FFFD, 33, 0);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2,
           5'd9, 32'hFFFF_FFFF, 33, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000,
           32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1, 0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000,
           32'hFFFF_FFFF, 5'd11, 32'h0, 1, 0);
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0,
           5'd12, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_by0", OP_REMU, 32'd5, 32'd0,
           5'd13, 32'd5, 1, 0);
    run_op("div_by0", OP_DIV, 32'd5, 32'd0,
           5'd17, 32'hFFFF_FFFF, 1, 0);
    run_op("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9,
           5'd14, 32'hFFFF_FFF2, 33, 0);
    run_op("rem_7_m3", OP_REM, 32'd7, 32'hFFFF_FFFD,
           5'd0, 32'd1, 33, 0);
    run_op("remu_max", OP_REMU, 32'hFFFF_FFFF, 32'd10,
           5'd16, 32'd5, 33, 0);
    run_op("divu_hold", OP_DIVU, 32'd100, 32'd7,
           5'd15, 32'd14, 33, 10);

    // Flush ten cycles into a divide, with a competing request.
    start_req(OP_DIV, 32'd100, 32'd7, 5'd20);
    repeat (9) @(posedge clk);
    #1;
    pending = 1'b0;
    flush = 1'b1;
    valid_i = 1'b1;
    aluop = OP_MUL;
    op1 = 32'd3;
    op2 = 32'd4;
    @(posedge clk); #1;
    flush = 1'b0;
    valid_i = 1'b0;
    check("flush_idle", ready_o, 1);
    check("flush_stall", stall_ex, 0);
    check("flush_valid", valid_o, 0);
    repeat (40) begin
      @(negedge clk);
      check("flush_no_accept", stall_ex, 0);
    end

    // Reset mid-multiply beats flush and valid_i.
    start_req(OP_MULHU, 32'd9, 32'd9, 5'd21);
    repeat (5) @(posedge clk);
    #1;
    pending = 1'b0;
    reset_n = 1'b0;
    flush = 1'b1;
    valid_i = 1'b1;
    aluop = OP_DIV;
    @(posedge clk); #1;
    check("rst_mid_ready", ready_o, 1);
    check("rst_mid_stall", stall_ex, 0);
    check("rst_mid_valid", valid_o, 0);
    check("rst_mid_data", regw_data, 0);
    reset_n = 1'b1;
    flush = 1'b0;
    valid_i = 1'b0;
    repeat (40) begin
      @(negedge clk);
      check("rst_no_accept", stall_ex, 0);
    end

    run_op("mul_after", OP_MUL, 32'd1234, 32'd5678,
           5'd18, 32'd7006652, MUL_LAT, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/stage_ex_muldiv.md
STAGE_EX_MULDIV -- requirements
Module: stage_ex_muldiv

Interface
REQ-001 Parameter XLEN SHALL be: default 32; operand and result width in bits, even, >= 8.
REQ-002 Parameter REG_ADDR_W SHALL be: default 5; destination register address width.
REQ-003 Port clk SHALL be: input, 1 bit; the single clock. One clock; reset is synchronous and active-low.
REQ-004 Port reset_n SHALL be: input, 1 bit; synchronous active-low reset.
REQ-005 Port flush SHALL be: input, 1 bit; abort any in-flight operation (branch mispredict).
REQ-006 Port valid_i / ready_o SHALL be: input / output, 1 bit each; request handshake.
REQ-007 Port aluop SHALL be: input, 3 bits; 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 Ports op1 and op2 SHALL be: input, XLEN bits each; rs1 and rs2 values.
REQ-009 Ports write_i and regw_addr_i SHALL be: input, 1 bit and REG_ADDR_W bits; writeback enable and destination.
REQ-010 Port valid_o / ready_i SHALL be: output / input, 1 bit each; result handshake.
REQ-011 Ports write_o, regw_addr_o and regw_data SHALL be: output, 1 bit, REG_ADDR_W bits and XLEN bits; writeback fields.
REQ-012 Port stall_ex SHALL be: output, 1 bit; high whenever the block is not IDLE.

Function
REQ-013 States SHALL be IDLE, MUL, DIV and DONE.
REQ-014 ready_o SHALL be high only in IDLE; a request is accepted on a clk edge with valid_i && ready_o && !flush.
REQ-015 On accept, the block SHALL register aluop, write_i and regw_addr_i, and compute absolute-value operands for signed ops.
REQ-016 IDLE SHALL go to MUL for aluop 0-3 and to DIV for aluop 4-7.
REQ-017 Exception: DIV/DIVU/REM/REMU with op2==0 SHALL go directly to DONE; DIV result all-ones, DIVU result all-ones, REM/REMU result = op1.
REQ-018 Exception: DIV/REM with op1 = -2^(XLEN-1) and op2 = -1 SHALL go directly to DONE; DIV result = op1, REM result = 0.
REQ-019 MUL state SHALL do iterative shift-add, 1 bit per cycle, for exactly XLEN cycles, counted by a log2(XLEN)+1-bit counter, then go to DONE.
REQ-020 DIV state SHALL do restoring division, 1 quotient bit per cycle, for exactly XLEN cycles, then go to DONE.
REQ-021 Result sign fix-up SHALL be: product negated if operand signs differ (MULH signed x signed, MULHSU signed x unsigned); quotient negated if signs differ; remainder takes the dividend sign.
REQ-022 Result selection SHALL be: MUL low XLEN bits; MULH/MULHSU/MULHU high XLEN bits of the 2*XLEN product.
REQ-023 Latency SHALL be: valid_o rises XLEN+1 cycles after the accept edge for normal ops, and 1 cycle after it for the REQ-017/018 cases.
REQ-024 In DONE, valid_o SHALL be 1 and regw_data, regw_addr_o and write_o SHALL be stable; DONE goes to IDLE on the edge where ready_i=1.
REQ-025 Back-to-back requests SHALL NOT overlap; a new request is accepted only in IDLE, i.e. one cycle after the DONE handshake.
REQ-026 flush SHALL force IDLE on the next edge from any state, drop the result (valid_o=0), and drop a same-cycle valid_i.
REQ-027 Outside DONE, valid_o, write_o, regw_addr_o and regw_data SHALL be 0.

Reset
REQ-028 When reset_n=0 at a clk edge, the state SHALL become IDLE and the counter 0.
REQ-029 Reset SHALL clear every output to 0 except ready_o, which reads 1 once IDLE is reached.
REQ-030 Reset mid-operation SHALL discard the operation with no valid_o pulse; reset has priority over flush and valid_i.

Configuration
REQ-031 The macro MULDIV_FAST_MUL_EN SHALL select the multiplier implementation.
REQ-032 With MULDIV_FAST_MUL_EN defined, MUL ops SHALL compute the full product combinationally at accept and go IDLE->DONE, with valid_o 1 cycle after accept; the MUL state is unreachable.
REQ-033 Without MULDIV_FAST_MUL_EN, the multiplier SHALL be the iterative one of REQ-019, with no hardware multiplier inferred.
REQ-034 Division SHALL be identical in both configurations.

Structure
REQ-035 The shared package SHALL hold the aluop encodings for MUL..REMU and the state enum typedef.
REQ-036 Divider datapath SHALL be a sub-module muldiv_divider (remainder/quotient registers, XLEN-step restoring loop, start/done pins), instantiated once.
REQ-037 The multiply datapath and sign fix-up SHALL stay in stage_ex_muldiv.

Verification
REQ-038 The bench SHALL check MUL 7 x -3 (XLEN=32): regw_data=0xFFFFFFEB, valid_o exactly 33 cycles after accept (1 cycle with MULDIV_FAST_MUL_EN).
REQ-039 The bench SHALL check MULHU 0xFFFFFFFF x 0xFFFFFFFF gives 0xFFFFFFFE, and MULH -1 x -1 gives 0.
REQ-040 The bench SHALL check DIV -7/2 gives 0xFFFFFFFD and REM -7/2 gives 0xFFFFFFFF; DIV 0x80000000/-1 gives 0x80000000 with valid_o 1 cycle after accept.
REQ-041 The bench SHALL check DIVU 5/0 gives 0xFFFFFFFF and REMU 5/0 gives 5, both with 1-cycle latency.
REQ-042 The bench SHALL check that with ready_i held 0 for 10 cycles in DONE, valid_o and regw_data stay stable, and that ready_o rises the cycle after ready_i=1.
REQ-043 The bench SHALL check that flush asserted mid-DIV (cycle 10) with valid_i=1 gives IDLE next cycle, no valid_o, and that request not accepted.
